// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: display-side bus of the seven-segment scan driver.
//   data     : hex value, nibble i drives digit i (digit 0 rightmost)
//   data_we  : one-cycle write strobe for data
//   blank_lz : blank leading-zero digits when 1
//   an       : active-low anode selects
//   d        : nibble for the hex-to-segment decoder
//   frame    : one-cycle pulse when a new displayed value is committed
interface seg_scan_driver_if #(
    parameter int N_DIG = 8
);
    logic [4*N_DIG-1:0] data;
    logic               data_we;
    logic               blank_lz;
    logic [N_DIG-1:0]   an;
    logic [3:0]         d;
    logic               frame;

    modport master (output data, data_we, blank_lz, input an, d, frame);
    modport slave  (input data, data_we, blank_lz, output an, d, frame);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed, double-buffered 8-digit seven-segment scan driver.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : seg_scan_driver_if slave (data/data_we/blank_lz in, an/d/frame out)
module seg_scan_driver #(
    parameter int N_DIG    = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               rstn,
    seg_scan_driver_if.slave   bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = N_DIG > 1 ? $clog2(N_DIG) : 1;

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [4*N_DIG-1:0] shadow;
    logic [4*N_DIG-1:0] pend_data;
    logic               pend;
    logic               tick;
    logic               wrap;
    logic               z;
    logic [N_DIG-1:0]   zero_up;
    logic               blank;
    logic [3:0]         d_nx;
    logic [N_DIG-1:0]   an_nx;

    assign tick = cnt == CW'(SCAN_DIV - 1);
    assign wrap = tick && idx == IW'(N_DIG - 1);

    always_comb begin
        // zero_up[i] is set when every nibble from i up to the top digit is zero
        z       = 1'b1;
        zero_up = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            z          = z && shadow[4*i +: 4] == 4'd0;
            zero_up[i] = z;
        end
        blank = bus.blank_lz && idx != '0 && zero_up[idx];
        d_nx  = shadow[{idx, 2'b00} +: 4];
        an_nx = blank ? '1 : ~(N_DIG'(1) << idx);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            idx       <= '0;
            shadow    <= '0;
            pend_data <= '0;
            pend      <= 1'b0;
            bus.an    <= '1;
            bus.d     <= '0;
            bus.frame <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                idx <= wrap ? '0 : idx + IW'(1);
            if (bus.data_we)
                pend_data <= bus.data;
            // a write landing on the wrap cycle bypasses the pending buffer
            if (wrap) begin
                shadow <= bus.data_we ? bus.data : pend ? pend_data : shadow;
                pend   <= 1'b0;
            end else if (bus.data_we) begin
                pend <= 1'b1;
            end
            bus.frame <= wrap;
            bus.d     <= d_nx;
            bus.an    <= an_nx;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver with N_DIG=8, SCAN_DIV=4 (32-cycle frame).
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rstn;
    int   ec;
    int   errors = 0;
    int   checks = 0;

    seg_scan_driver_if #(.N_DIG(8)) bus ();

    seg_scan_driver #(.N_DIG(8), .SCAN_DIV(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // one rising edge per call; inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(negedge clk);
        ec++;
    endtask

    task automatic goto(input int t);
        while (ec < t) cyc();
    endtask

    task automatic wr(input logic [31:0] v);
        bus.data    = v;
        bus.data_we = 1'b1;
        cyc();
        bus.data_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        bus.data     = '0;
        bus.data_we  = 1'b0;
        bus.blank_lz = 1'b0;
        rstn         = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", bus.an); end
        checks++; if (bus.d !== 4'h0) begin errors++; $display("FAIL reset_d got %h want 0", bus.d); end
        checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", bus.frame); end
        rstn = 1'b1;
        ec   = 0;
        for (int e = 1; e <= 33; e++) begin
            cyc();
            exp_an = ~(8'd1 << (((e - 1) / 4) % 8));
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL scan_an edge %0d got %h want %h", e, bus.an, exp_an); end
            checks++; if (bus.frame !== (e == 32)) begin errors++; $display("FAIL scan_frame edge %0d got %b want %b", e, bus.frame, e == 32); end
            if (e == 1) begin
                checks++; if (bus.d !== 4'h0) begin errors++; $display("FAIL first_d got %h want 0", bus.d); end
            end
        end
    endtask

    task automatic test_write_commit();
        logic [3:0] exp_d [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
        logic [7:0] exp_an;
        goto(37);
        wr(32'h1234_ABCD);
        goto(63);
        checks++; if (bus.d !== 4'h0) begin errors++; $display("FAIL precommit_d got %h want 0", bus.d); end
        goto(64);
        checks++; if (bus.frame !== 1'b1) begin errors++; $display("FAIL commit_frame got %b want 1", bus.frame); end
        for (int k = 0; k < 8; k++) begin
            goto(64 + 4*k + 1);
            exp_an = ~(8'd1 << k);
            checks++; if (bus.d !== exp_d[k]) begin errors++; $display("FAIL commit_d digit %0d got %h want %h", k, bus.d, exp_d[k]); end
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL commit_an digit %0d got %h want %h", k, bus.an, exp_an); end
        end
    endtask

    task automatic test_last_wins();
        logic [7:0] exp_an;
        goto(100);
        wr(32'h1111_1111);
        goto(110);
        wr(32'h2222_2222);
        goto(113);
        checks++; if (bus.d !== 4'h4) begin errors++; $display("FAIL pending_hidden_d got %h want 4", bus.d); end
        goto(128);
        checks++; if (bus.frame !== 1'b1) begin errors++; $display("FAIL last_frame got %b want 1", bus.frame); end
        for (int k = 0; k < 8; k++) begin
            goto(128 + 4*k + 1);
            exp_an = ~(8'd1 << k);
            checks++; if (bus.d !== 4'h2) begin errors++; $display("FAIL last_d digit %0d got %h want 2", k, bus.d); end
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL last_an digit %0d got %h want %h", k, bus.an, exp_an); end
        end
    endtask

    task automatic test_wrap_write();
        logic [3:0] exp_d;
        logic [7:0] exp_an;
        goto(140);
        wr(32'h1111_1111);
        goto(159);
        wr(32'h0000_00FF);
        checks++; if (bus.frame !== 1'b1) begin errors++; $display("FAIL wrap_frame got %b want 1", bus.frame); end
        for (int k = 0; k < 8; k++) begin
            goto(160 + 4*k + 1);
            exp_d  = k < 2 ? 4'hF : 4'h0;
            exp_an = ~(8'd1 << k);
            checks++; if (bus.d !== exp_d) begin errors++; $display("FAIL wrap_d digit %0d got %h want %h", k, bus.d, exp_d); end
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL wrap_an digit %0d got %h want %h", k, bus.an, exp_an); end
        end
    endtask

    task automatic test_blank();
        logic [3:0] exp_d  [8] = '{4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [7:0] exp_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        goto(190);
        bus.blank_lz = 1'b1;
        wr(32'h0000_0A05);
        for (int k = 0; k < 8; k++) begin
            goto(192 + 4*k + 1);
            checks++; if (bus.d !== exp_d[k]) begin errors++; $display("FAIL blank_d digit %0d got %h want %h", k, bus.d, exp_d[k]); end
            checks++; if (bus.an !== exp_an[k]) begin errors++; $display("FAIL blank_an digit %0d got %h want %h", k, bus.an, exp_an[k]); end
        end
        wr(32'h0000_0000);
        goto(225);
        checks++; if (bus.an !== 8'hFE) begin errors++; $display("FAIL zero_an0 got %h want fe", bus.an); end
        checks++; if (bus.d !== 4'h0) begin errors++; $display("FAIL zero_d0 got %h want 0", bus.d); end
        goto(229);
        checks++; if (bus.an !== 8'hFF) begin errors++; $display("FAIL zero_an1 got %h want ff", bus.an); end
        goto(249);
        checks++; if (bus.an !== 8'hFF) begin errors++; $display("FAIL zero_an6 got %h want ff", bus.an); end
        bus.blank_lz = 1'b0;
        goto(253);
        checks++; if (bus.an !== 8'h7F) begin errors++; $display("FAIL noblank_an7 got %h want 7f", bus.an); end
        goto(257);
        checks++; if (bus.an !== 8'hFE) begin errors++; $display("FAIL noblank_an0 got %h want fe", bus.an); end
        goto(269);
        checks++; if (bus.an !== 8'hF7) begin errors++; $display("FAIL noblank_an3 got %h want f7", bus.an); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_an;
        goto(300);
        wr(32'h5555_5555);
        goto(305);
        checks++; if (bus.an !== 8'hEF) begin errors++; $display("FAIL prereset_an got %h want ef", bus.an); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.an !== 8'hFF) begin errors++; $display("FAIL async_an got %h want ff", bus.an); end
        checks++; if (bus.d !== 4'h0) begin errors++; $display("FAIL async_d got %h want 0", bus.d); end
        checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL async_frame got %b want 0", bus.frame); end
        cyc();
        cyc();
        rstn = 1'b1;
        ec   = 0;
        goto(1);
        checks++; if (bus.an !== 8'hFE) begin errors++; $display("FAIL restart_an got %h want fe", bus.an); end
        for (int k = 0; k < 8; k++) begin
            goto(32 + 4*k + 1);
            exp_an = ~(8'd1 << k);
            checks++; if (bus.d !== 4'h0) begin errors++; $display("FAIL discard_d digit %0d got %h want 0", k, bus.d); end
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL discard_an digit %0d got %h want %h", k, bus.an, exp_an); end
        end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_last_wins();
        test_wrap_write();
        test_blank();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scan driver for an 8-digit common-anode seven-segment display. Holds a 32-bit hex value and cycles one digit at a time through the display. Each scan step outputs that digit's 4-bit nibble to the downstream hex-to-segment decoder and drives the matching active-low anode. Display updates are double-buffered so a new value only appears at a frame boundary, which prevents tearing.

Parameters:
N_DIG, 8, number of digits scanned (1..8)
SCAN_DIV, 100000, clock cycles each digit stays lit (>=2; 1 ms at 100 MHz)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
data  input  4*N_DIG  hex value to show; nibble i goes to digit i (digit 0 is rightmost)
data_we  input  1  one-cycle write strobe; captures data into the pending buffer
blank_lz  input  1  when 1, leading-zero digits are blanked
an  output  N_DIG  anode selects, active-low, registered
d  output  4  nibble for the seven-segment decoder, registered
frame  output  1  one-cycle pulse when the displayed value is committed (index wraps to 0)

Behaviour:
- Single clock domain (clk). Asynchronous active-low reset (rstn); all state clears immediately when rstn=0.
- Reset values:
  - Internal state: cnt=0, idx=0, shadow=0, pend_data=0, pend=0.
  - Outputs: an = all ones (all digits off), d=0, frame=0.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and then wraps to 0.
  - tick = (cnt==SCAN_DIV-1).
- Digit index:
  - On tick, idx <= (idx==N_DIG-1) ? 0 : idx+1.
  - wrap = tick && idx==N_DIG-1.
- Pending buffer:
  - data_we=1 sets pend_data<=data and pend<=1.
  - A later write before commit overwrites pend_data. Last write wins.
- Commit (on wrap):
  - If data_we=1 in the same cycle, shadow<=data (bypass, the newest value wins) and pend<=0.
  - Else, if pend=1, shadow<=pend_data and pend<=0.
  - Else, shadow is unchanged.
  - In all three cases, frame<=1 for exactly one cycle. frame=0 otherwise.
- Output stage (registered every cycle from the current idx and shadow, so outputs lag idx by 1 cycle):
  - d <= shadow[4*idx+3 : 4*idx].
  - an <= ~(1<<idx), unless digit idx is blanked, in which case an <= all ones.
- Blanking rule: digit idx is blanked when all of the following hold:
  - blank_lz=1,
  - idx>0,
  - every nibble at positions idx..N_DIG-1 of shadow is 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- blank_lz is sampled live each cycle; a change takes effect on the next output update.
- Reset asserted mid-frame aborts the scan and discards any pending write. After rstn deasserts, scanning restarts at digit 0, showing 0.
- Only one anode is ever low at a time; an is never 0 in more than one bit.
- A write with no commit yet leaves the visible value unchanged. The worst-case update latency is one full frame, N_DIG*SCAN_DIV cycles.

Test Plan:
- Reset behaviour (SCAN_DIV=4, N_DIG=8): release rstn, then check cycle by cycle.
  - First edge after release: an=8'hFE, d=0.
  - After 4 cycles: an=8'hFD.
  - After 32 cycles: back at an=8'hFE and frame pulses once.
- Write and commit: pulse data_we with data=32'h1234_ABCD at cycle 5.
  - Display is unchanged (d=0) until the first wrap, where frame=1.
  - Next frame shows d=D,C,B,A,4,3,2,1 on an=FE,FD,FB,F7,EF,DF,BF,7F.
- Last write wins: write 32'h1111_1111, then 32'h2222_2222 within the same frame.
  - The next frame shows only 2 on every digit.
- Write on the wrap cycle: assert data_we with 32'h0000_00FF exactly on the wrap cycle.
  - That value is committed immediately and shows in the very next frame.
- Leading-zero blanking: data=32'h0000_0A05 with blank_lz=1.
  - Digits 0..2 light with d=5,0,A.
  - Digits 3..7 give an=8'hFF.
  - data=0 lights digit 0 only.
  - With blank_lz=0, all 8 digits light.
- Reset mid-operation: assert rstn=0 mid-frame while a write is pending.
  - an goes to 8'hFF immediately, without waiting for a clock edge.
  - After release, the display shows 0 and the pending value never appears.
